// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI4-lite slave backed by a word-addressed memory array
//
// Purpose: the far end of the core's AXI4-lite master port. It holds one array of
// 32-bit words at BASE_ADDR. The read and write channels each run their own FSM.
// Byte strobes are honoured. Accesses outside the array return SLVERR.
//
// Optional feature macro: AXI_MEM_ALIGN_CHECK_EN
//   defined   - an access with addr[1:0] != 0 returns SLVERR. A read returns 0 and a
//               write leaves memory untouched.
//   undefined - addr[1:0] is ignored.
//
// Ports:
//   CLK, RST                      clock (rising edge) and asynchronous active-high reset
//   S_AXI_AW* (VALID/READY/ADDR/PROT)  write address channel; PROT is ignored
//   S_AXI_W*  (VALID/READY/DATA/STRB)  write data channel
//   S_AXI_B*  (VALID/READY/RESP)       write response channel
//   S_AXI_AR* (VALID/READY/ADDR/PROT)  read address channel; PROT is ignored
//   S_AXI_R*  (VALID/READY/DATA/RESP)  read data channel

`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module axi_lite_mem_slave #(
    parameter int                           MEM_DEPTH_WORDS = 1024,
    parameter logic [`C_AXI_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                            CLK,
    input  logic                            RST,

    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [`C_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,

    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    input  logic [`C_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [`C_AXI_STROBE_WIDTH-1:0]  S_AXI_WSTRB,

    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    output logic [1:0]                      S_AXI_BRESP,

    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    input  logic [`C_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,

    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [`C_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP
);

    localparam int AW = `C_AXI_ADDR_WIDTH;
    localparam int DW = `C_AXI_DATA_WIDTH;
    localparam int SW = `C_AXI_STROBE_WIDTH;
    localparam int IW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The protection bits carry no meaning for a plain memory.
    logic unused_prot;
    assign unused_prot = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT};

    logic [DW-1:0] mem [MEM_DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t      r_state, r_state_next;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic [AW-1:0] rd_off;
    logic [IW-1:0] rd_idx;
    logic          rd_ok;

    always_comb begin
        rd_off = S_AXI_ARADDR - BASE_ADDR;
        rd_idx = rd_off[IW+1:2];
        rd_ok  = (S_AXI_ARADDR >= BASE_ADDR) && ((rd_off >> 2) < AW'(MEM_DEPTH_WORDS));
`ifdef AXI_MEM_ALIGN_CHECK_EN
        if (S_AXI_ARADDR[1:0] != 2'b00) begin
            rd_ok = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: if (S_AXI_ARVALID) r_state_next = R_DATA;
            R_DATA: if (S_AXI_RREADY)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // mem is sampled with a non-blocking read, so a write that commits on the same
    // edge is not yet visible here. The read therefore returns the old word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (r_state == R_IDLE && S_AXI_ARVALID) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? mem[rd_idx] : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_state == R_DATA && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    w_state_t      w_state, w_state_next;
    logic          aw_done, w_done;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;

    logic          aw_hs, w_hs, commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [AW-1:0] wr_off;
    logic [IW-1:0] wr_idx;
    logic          wr_ok;

    assign S_AXI_AWREADY = (w_state == W_IDLE) && !aw_done;
    assign S_AXI_WREADY  = (w_state == W_IDLE) && !w_done;

    // A held half is used if it is already latched. Otherwise the half taken this
    // cycle is used, so AW and W may arrive in either order or together.
    always_comb begin
        aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs    = S_AXI_WVALID && S_AXI_WREADY;
        commit  = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
        wr_addr = aw_done ? aw_addr_q : S_AXI_AWADDR;
        wr_data = w_done  ? w_data_q  : S_AXI_WDATA;
        wr_strb = w_done  ? w_strb_q  : S_AXI_WSTRB;
        wr_off  = wr_addr - BASE_ADDR;
        wr_idx  = wr_off[IW+1:2];
        wr_ok   = (wr_addr >= BASE_ADDR) && ((wr_off >> 2) < AW'(MEM_DEPTH_WORDS));
`ifdef AXI_MEM_ALIGN_CHECK_EN
        if (wr_addr[1:0] != 2'b00) begin
            wr_ok = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE: if (commit)       w_state_next = W_RESP;
            W_RESP: if (S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_done   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_done   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (w_state == W_RESP && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
        end
    end

    // The memory has no reset. Writes are blocked while RST is high so that a
    // transaction caught by reset commits nothing.
    always_ff @(posedge CLK) begin
        if (!RST && commit && wr_ok) begin
            for (int i = 0; i < SW; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - directed self-checking bench for axi_lite_mem_slave

`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module tb_axi_lite_mem_slave;

    localparam int DEPTH = 1024;

    logic                           CLK = 1'b0;
    logic                           RST = 1'b1;
    logic                           S_AXI_AWVALID = 1'b0;
    logic                           S_AXI_AWREADY;
    logic [`C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR = '0;
    logic [2:0]                     S_AXI_AWPROT = '0;
    logic                           S_AXI_WVALID = 1'b0;
    logic                           S_AXI_WREADY;
    logic [`C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA = '0;
    logic [`C_AXI_STROBE_WIDTH-1:0] S_AXI_WSTRB = '0;
    logic                           S_AXI_BVALID;
    logic                           S_AXI_BREADY = 1'b0;
    logic [1:0]                     S_AXI_BRESP;
    logic                           S_AXI_ARVALID = 1'b0;
    logic                           S_AXI_ARREADY;
    logic [`C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR = '0;
    logic [2:0]                     S_AXI_ARPROT = '0;
    logic                           S_AXI_RVALID;
    logic                           S_AXI_RREADY = 1'b0;
    logic [`C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                     S_AXI_RRESP;

    int n_checks = 0;
    int n_pass   = 0;

    axi_lite_mem_slave #(
        .MEM_DEPTH_WORDS(DEPTH),
        .BASE_ADDR      (32'h0000_0000)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // AW and W are presented together. BREADY is held low for bwait cycles after BVALID appears.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int bwait, output logic [1:0] resp);
        @(negedge CLK);
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = a;
        S_AXI_WVALID  = 1'b1; S_AXI_WDATA  = d; S_AXI_WSTRB = s;
        S_AXI_BREADY  = 1'b0;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("b_latency", S_AXI_BVALID, 1);
        resp = S_AXI_BRESP;
        for (int i = 0; i < bwait; i++) begin
            @(negedge CLK);
            check("b_hold_valid", S_AXI_BVALID, 1);
            check("b_hold_resp", S_AXI_BRESP, resp);
            check("b_hold_awready", S_AXI_AWREADY, 0);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        check("b_done", S_AXI_BVALID, 0);
    endtask

    // RREADY is held low for rwait cycles after RVALID appears.
    task automatic rd(input logic [31:0] a, input int rwait,
                      output logic [31:0] data, output logic [1:0] resp);
        @(negedge CLK);
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = a; S_AXI_RREADY = 1'b0;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        check("r_latency", S_AXI_RVALID, 1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < rwait; i++) begin
            @(negedge CLK);
            check("r_hold_valid", S_AXI_RVALID, 1);
            check("r_hold_data", S_AXI_RDATA, data);
            check("r_hold_arready", S_AXI_ARREADY, 0);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0;
        check("r_done", S_AXI_RVALID, 0);
        check("r_done_arready", S_AXI_ARREADY, 1);
    endtask

    logic [31:0] d;
    logic [1:0]  r;

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_awready", S_AXI_AWREADY, 1);
        check("rst_wready", S_AXI_WREADY, 1);
        check("rst_arready", S_AXI_ARREADY, 1);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);

        // Full word write, then a read with RREADY held low for 4 cycles.
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, r);
        check("wr_full_bresp", r, 2'b00);
        rd(32'h10, 4, d, r);
        check("rd_full_data", d, 32'hDEADBEEF);
        check("rd_full_rresp", r, 2'b00);

        // Only byte 0 is written.
        wr(32'h10, 32'h000000AA, 4'b0001, 0, r);
        rd(32'h10, 0, d, r);
        check("rd_strb1_data", d, 32'hDEADBEAA);

        // No strobes set: the word stays the same and the response is OKAY.
        wr(32'h10, 32'h11223344, 4'b0000, 0, r);
        check("wr_strb0_bresp", r, 2'b00);
        rd(32'h10, 0, d, r);
        check("rd_strb0_data", d, 32'hDEADBEAA);

        // Misaligned read.
        rd(32'h11, 0, d, r);
`ifdef AXI_MEM_ALIGN_CHECK_EN
        check("rd_misalign_rresp", r, 2'b10);
        check("rd_misalign_data", d, 32'h0);
`else
        check("rd_misalign_rresp", r, 2'b00);
        check("rd_misalign_data", d, 32'hDEADBEAA);
`endif

        // W is sent 3 cycles before AW.
        @(negedge CLK);
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_WVALID = 1'b0;
        check("wfirst_wready_low", S_AXI_WREADY, 0);
        check("wfirst_awready", S_AXI_AWREADY, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("wfirst_no_bvalid", S_AXI_BVALID, 0);
        end
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h20;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid", S_AXI_BVALID, 1);
        check("wfirst_bresp", S_AXI_BRESP, 2'b00);
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        check("wfirst_bdone", S_AXI_BVALID, 0);
        check("wfirst_wready_back", S_AXI_WREADY, 1);
        rd(32'h20, 0, d, r);
        check("rd_wfirst_data", d, 32'h12345678);

        // Out of range. Index 1024 would alias word 0 if the range check were missing.
        wr(32'h0, 32'hCAFEF00D, 4'hF, 0, r);
        rd(32'h0 + 4 * DEPTH, 0, d, r);
        check("rd_oor_rresp", r, 2'b10);
        check("rd_oor_data", d, 32'h0);
        wr(32'h0 + 4 * DEPTH, 32'hFFFFFFFF, 4'hF, 4, r);
        check("wr_oor_bresp", r, 2'b10);
        rd(32'h0, 0, d, r);
        check("rd_after_oor_data", d, 32'hCAFEF00D);

        // A write commit and a read of the same word on the same edge: the read gets the old value.
        @(negedge CLK);
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h10;
        S_AXI_WVALID  = 1'b1; S_AXI_WDATA  = 32'h55555555; S_AXI_WSTRB = 4'hF;
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h10;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("coll_rdata_old", S_AXI_RDATA, 32'hDEADBEAA);
        check("coll_bvalid", S_AXI_BVALID, 1);
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        rd(32'h10, 0, d, r);
        check("coll_rd_new", d, 32'h55555555);

        // Reset while in R_DATA and W_RESP. The write to 0x30 has already committed.
        @(negedge CLK);
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h10;
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h30;
        S_AXI_WVALID  = 1'b1; S_AXI_WDATA  = 32'h0BADBEEF; S_AXI_WSTRB = 4'hF;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("pre_rst_rvalid", S_AXI_RVALID, 1);
        check("pre_rst_bvalid", S_AXI_BVALID, 1);
        RST = 1'b1;
        #1;
        check("async_rst_rvalid", S_AXI_RVALID, 0);
        check("async_rst_bvalid", S_AXI_BVALID, 0);
        check("async_rst_rdata", S_AXI_RDATA, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_arready", S_AXI_ARREADY, 1);
        check("post_rst_awready", S_AXI_AWREADY, 1);
        check("post_rst_wready", S_AXI_WREADY, 1);
        rd(32'h20, 0, d, r);
        check("post_rst_rd20", d, 32'h12345678);
        rd(32'h30, 0, d, r);
        check("post_rst_rd30", d, 32'h0BADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
AXI4-lite slave (responder) backing a single word-addressed memory array. It is the far end of the core's AXI4-lite master port and serves both instruction fetch and load/store traffic in simulation and FPGA builds. Read and write channels run independent state machines. Byte strobes are honoured, and out-of-range accesses return SLVERR.

Parameters:
MEM_DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two not required)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset; one clock; asynchronous, active-high
S_AXI_AWVALID  input  1  write address valid
S_AXI_AWREADY  output  1  write address ready
S_AXI_AWADDR  input  `C_AXI_ADDR_WIDTH  write byte address
S_AXI_AWPROT  input  3  ignored
S_AXI_WVALID  input  1  write data valid
S_AXI_WREADY  output  1  write data ready
S_AXI_WDATA  input  `C_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  input  `C_AXI_STROBE_WIDTH  byte enables; bit i covers WDATA[8i+7:8i]
S_AXI_BVALID  output  1  write response valid
S_AXI_BREADY  input  1  write response ready
S_AXI_BRESP  output  2  2'b00 OKAY, 2'b10 SLVERR
S_AXI_ARVALID  input  1  read address valid
S_AXI_ARREADY  output  1  read address ready
S_AXI_ARADDR  input  `C_AXI_ADDR_WIDTH  read byte address
S_AXI_ARPROT  input  3  ignored
S_AXI_RVALID  output  1  read data valid
S_AXI_RREADY  input  1  read data ready
S_AXI_RDATA  output  `C_AXI_DATA_WIDTH  read data
S_AXI_RRESP  output  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (RST high, asynchronous): both FSMs go to idle. BVALID=0, RVALID=0, RDATA=0, RRESP=0, BRESP=0. AWREADY, WREADY and ARREADY follow state and are therefore 1 in idle. Memory contents are not reset.
- Reset mid-transaction: any in-flight transaction is dropped. No partial write is committed unless its commit edge already occurred.
- Decode: idx = (addr - BASE_ADDR) >> 2. In range iff addr >= BASE_ADDR and idx < MEM_DEPTH_WORDS. addr[1:0] is ignored (see Optional Feature).
- Read FSM, states R_IDLE and R_DATA:
  - ARREADY = (state == R_IDLE), driven combinationally from state.
  - R_IDLE with ARVALID: the handshake completes. On the same edge, RDATA is registered from mem[idx] (0 if out of range), RRESP is set to OKAY or SLVERR, RVALID is set to 1, and the FSM moves to R_DATA.
  - R_DATA: RVALID, RDATA and RRESP are held stable until RREADY. On the RVALID && RREADY edge, RVALID goes to 0 and the FSM returns to R_IDLE.
  - Latency is 1 cycle from AR handshake to RVALID. Peak throughput is one read per 2 cycles.
- Write FSM, states W_IDLE and W_RESP:
  - Separate aw_done and w_done flags latch address and data/strobe independently. AW and W may arrive in either order or in the same cycle.
  - AWREADY = (W_IDLE && !aw_done). WREADY = (W_IDLE && !w_done).
  - Commit happens on the edge where both are held or completing. For each in-range strobe bit, mem[idx] byte i is updated with that WDATA byte. Out-of-range writes leave memory untouched.
  - On the commit edge: BVALID=1, BRESP=OKAY or SLVERR, and the FSM moves to W_RESP.
  - W_RESP: BVALID and BRESP are held until BREADY. On the handshake edge, BVALID goes to 0, both flags clear, and the FSM returns to W_IDLE.
  - WSTRB=0 is legal: no bytes change and BRESP=OKAY.
- Read/write collision: if a write commits on the same edge as an AR handshake to the same word, RDATA returns the pre-write value (read-before-write).
- Channels never block each other. Ordering between read and write channels is not guaranteed beyond the collision rule.
- No outputs depend combinationally on VALID/READY inputs. Only the READY outputs are state-derived.

Optional Feature:
- Macro: AXI_MEM_ALIGN_CHECK_EN.
- Defined: a read or write with addr[1:0] != 0 returns SLVERR. Reads return RDATA=0. Writes do not modify memory. Handshake timing is unchanged.
- Undefined: addr[1:0] is ignored and the access proceeds word-aligned with OKAY (if in range).

Test Plan:
- Write AW=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF in the same cycle, BREADY=1 -> BVALID one cycle after handshake with BRESP=0. Then read 0x10 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=0.
- Partial strobe: word 0x10=0xDEADBEEF, write 0x000000AA with WSTRB=4'b0001 -> read returns 0xDEADBEAA. WSTRB=4'b0000 -> unchanged, BRESP=0.
- W sent 3 cycles before AW (addr 0x20, data 0x12345678) -> WREADY drops after the W handshake, commit only after AW, read of 0x20 returns 0x12345678.
- Backpressure: RREADY held low 4 cycles after read of 0x10 -> RVALID and RDATA stable, ARREADY=0 throughout. Same check for BREADY low with BVALID/BRESP stable.
- Out of range: read at BASE_ADDR + 4*MEM_DEPTH_WORDS -> RRESP=2'b10, RDATA=0. Write there -> BRESP=2'b10, memory unchanged. With AXI_MEM_ALIGN_CHECK_EN, read 0x11 -> RRESP=2'b10.
- Reset pulse while in R_DATA and W_RESP -> RVALID=BVALID=0 immediately. ARREADY=AWREADY=WREADY=1 after RST deasserts. Prior committed data is still readable.
